// File: rtl/wb_gpio_irq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gpio_pkg
// Brief    : Register offsets and byte-lane helper for the wb_gpio_irq block
// Revision : 1.0 - initial release
// ============================================================================
package gpio_pkg;

  // Byte offsets of the registers; only address bits [4:2] are decoded
  localparam logic [4:0] GPIO_IN      = 5'h00;
  localparam logic [4:0] GPIO_OUT     = 5'h04;
  localparam logic [4:0] GPIO_DIR     = 5'h08;
  localparam logic [4:0] GPIO_SET     = 5'h0C;
  localparam logic [4:0] GPIO_CLR     = 5'h10;
  localparam logic [4:0] GPIO_IRQ_EN  = 5'h14;
  localparam logic [4:0] GPIO_RISE_EN = 5'h18;
  localparam logic [4:0] GPIO_FALL_EN = 5'h1C;

  // Replace the bytes of old_val whose lane enable is set with new_val bytes
  function automatic logic [31:0] apply_sel(input logic [31:0] old_val,
                                            input logic [31:0] new_val,
                                            input logic [3:0]  sel);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_gpio_irq_if.sv
`default_nettype none
// ============================================================================
// Module   : wb_gpio_irq_if
// Brief    : Wishbone classic bus bundle between the SoC master and the GPIO
// Revision : 1.0 - initial release
// ============================================================================
interface wb_gpio_irq_if;
  logic [4:0]  wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_ack_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    output wb_dat_o, wb_ack_o
  );
endinterface
`default_nettype wire

// File: rtl/wb_gpio_irq_sync_debounce.sv
`default_nettype none
// ============================================================================
// Module   : gpio_sync_debounce
// Brief    : Pad synchroniser plus optional tick-sampled debouncer
// Revision : 1.0 - initial release
// ============================================================================
module gpio_sync_debounce #(
  parameter int WIDTH        = 8,
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_DIV = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] gpio_i,
  output logic [WIDTH-1:0] din
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
  logic [WIDTH-1:0]                  w_sync_out;

  assign w_sync_out = r_sync[SYNC_STAGES-1];

  // Metastability chain: stage 0 captures the raw pads
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_sync <= '0;
    else       r_sync <= {r_sync[SYNC_STAGES-2:0], gpio_i};
  end

  generate
    if (DEBOUNCE_DIV == 0) begin : g_bypass
      assign din = w_sync_out;
    end else begin : g_debounce
      localparam int CW = $clog2(DEBOUNCE_DIV);

      logic [CW-1:0]    r_cnt;
      logic [WIDTH-1:0] r_samp;
      logic [WIDTH-1:0] r_din;
      logic [WIDTH-1:0] w_agree;
      logic             w_tick;

      assign w_tick  = (r_cnt == CW'(DEBOUNCE_DIV - 1));
      // A bit is accepted only when this tick's sample repeats the last one
      assign w_agree = ~(w_sync_out ^ r_samp);

      // Shared tick counter plus per-bit sample and accepted value
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          r_cnt  <= '0;
          r_samp <= '0;
          r_din  <= '0;
        end else begin
          r_cnt <= w_tick ? '0 : r_cnt + CW'(1);
          if (w_tick) begin
            r_samp <= w_sync_out;
            r_din  <= (r_din & ~w_agree) | (w_sync_out & w_agree);
          end
        end
      end

      assign din = r_din;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/wb_gpio_irq.sv
`default_nettype none
// ============================================================================
// Module   : wb_gpio_irq
// Brief    : Wishbone GPIO with atomic set/clear and edge interrupts
// Revision : 1.0 - initial release
// ============================================================================
module wb_gpio_irq
  import gpio_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_DIV = 0
) (
  input  logic             clock,
  input  logic             reset,
  wb_gpio_irq_if.slave     wb,
  input  logic [WIDTH-1:0] gpio_i,
  output logic [WIDTH-1:0] gpio_o,
  output logic [WIDTH-1:0] gpio_dir_o,
  output logic             irq_o
);

  logic [WIDTH-1:0] w_din;
  logic [WIDTH-1:0] r_out, r_dir, r_irq_en, r_rise_en, r_fall_en;
  logic [WIDTH-1:0] r_status, r_prev;
  logic             r_ack, r_irq;
  logic [31:0]      r_dat;

  logic             w_req, w_wr;
  logic [4:0]       w_off;
  logic [31:0]      w_lane, w_m_out, w_m_dir, w_m_ien, w_m_ren, w_m_fen;
  logic [31:0]      w_rdata;
  logic [WIDTH-1:0] w_w1c, w_rise, w_fall;
  logic             w_unused;

  gpio_sync_debounce #(
    .WIDTH        (WIDTH),
    .SYNC_STAGES  (SYNC_STAGES),
    .DEBOUNCE_DIV (DEBOUNCE_DIV)
  ) u_sync (
    .clock  (clock),
    .reset  (reset),
    .gpio_i (gpio_i),
    .din    (w_din)
  );

  // A new transfer is accepted only while ack is low, giving 2-cycle transfers
  assign w_req = wb.wb_cyc_i & wb.wb_stb_i & ~r_ack;
  assign w_wr  = w_req & wb.wb_we_i;
  assign w_off = {wb.wb_adr_i[4:2], 2'b00};

  // Byte-lane merges; SET/CLR/W1C treat unselected lanes as zero
  always_comb begin
    w_lane  = apply_sel(32'h0, wb.wb_dat_i, wb.wb_sel_i);
    w_m_out = apply_sel(32'(r_out),     wb.wb_dat_i, wb.wb_sel_i);
    w_m_dir = apply_sel(32'(r_dir),     wb.wb_dat_i, wb.wb_sel_i);
    w_m_ien = apply_sel(32'(r_irq_en),  wb.wb_dat_i, wb.wb_sel_i);
    w_m_ren = apply_sel(32'(r_rise_en), wb.wb_dat_i, wb.wb_sel_i);
    w_m_fen = apply_sel(32'(r_fall_en), wb.wb_dat_i, wb.wb_sel_i);
  end

  // Read mux: offset 0x1C reads back STATUS, write-only offsets read 0
  always_comb begin
    w_rdata = 32'h0;
    case (w_off)
      GPIO_IN:      w_rdata = 32'(w_din);
      GPIO_OUT:     w_rdata = 32'(r_out);
      GPIO_DIR:     w_rdata = 32'(r_dir);
      GPIO_IRQ_EN:  w_rdata = 32'(r_irq_en);
      GPIO_RISE_EN: w_rdata = 32'(r_rise_en);
      GPIO_FALL_EN: w_rdata = 32'(r_status);
      default:      w_rdata = 32'h0;
    endcase
  end

  // Bus response: ack one cycle after request, data only alongside ack
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ack <= 1'b0;
      r_dat <= 32'h0;
    end else begin
      r_ack <= w_req;
      r_dat <= (w_req && !wb.wb_we_i) ? w_rdata : 32'h0;
    end
  end

  // Control registers commit on the same edge that raises ack
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_out     <= '0;
      r_dir     <= '0;
      r_irq_en  <= '0;
      r_rise_en <= '0;
      r_fall_en <= '0;
    end else if (w_wr) begin
      case (w_off)
        GPIO_OUT:     r_out     <= w_m_out[WIDTH-1:0];
        GPIO_SET:     r_out     <= r_out | w_lane[WIDTH-1:0];
        GPIO_CLR:     r_out     <= r_out & ~w_lane[WIDTH-1:0];
        GPIO_DIR:     r_dir     <= w_m_dir[WIDTH-1:0];
        GPIO_IRQ_EN:  r_irq_en  <= w_m_ien[WIDTH-1:0];
        GPIO_RISE_EN: r_rise_en <= w_m_ren[WIDTH-1:0];
        GPIO_FALL_EN: r_fall_en <= w_m_fen[WIDTH-1:0];
        default: ;
      endcase
    end
  end

  assign w_w1c  = (w_wr && (w_off == GPIO_IN)) ? w_lane[WIDTH-1:0] : '0;
  assign w_rise = w_din & ~r_prev & r_rise_en;
  assign w_fall = ~w_din & r_prev & r_fall_en;

  // Edge capture into sticky status; a new edge beats a same-cycle W1C
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_prev   <= '0;
      r_status <= '0;
      r_irq    <= 1'b0;
    end else begin
      r_prev   <= w_din;
      r_status <= (r_status & ~w_w1c) | w_rise | w_fall;
      r_irq    <= |(r_status & r_irq_en);
    end
  end

  assign wb.wb_ack_o = r_ack;
  assign wb.wb_dat_o = r_dat;
  assign gpio_o      = r_out;
  assign gpio_dir_o  = r_dir;
  assign irq_o       = r_irq;

  // Byte-address bits and lanes above WIDTH are intentionally ignored
  assign w_unused = &{1'b0, wb.wb_adr_i[1:0], w_lane, w_m_out, w_m_dir,
                      w_m_ien, w_m_ren, w_m_fen};

endmodule
`default_nettype wire
